// File: rtl/sync_down_counter_pkg.sv
// Shared counter types: run state and load-value clamp.
// Pure declarations; no clocked logic or backpressure here.
package sync_down_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned clamp_val(input int unsigned val, input int unsigned max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-shot or auto-reload mode and a registered terminal tick.
// Latency: q shows the loaded value one edge after load; tick follows the terminal edge by one cycle.
// No backpressure: enb gates decrements, load always wins over counting.
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int          width     = 3,
    parameter int unsigned max_value = 7
) (
    input  logic             ck,
    input  logic             rst_s,
    input  logic             enb,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             periodic,
    output logic [width-1:0] q,
    output logic             cnt_zero,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [width-1:0] rld, rld_n;
    logic [width-1:0] q_n;
    logic             tick_n;
    logic [width-1:0] eff;
    logic             terminal;

    assign eff      = width'(clamp_val(32'(load_val), max_value));
    assign terminal = (q == width'(1));

    always_ff @(posedge ck or posedge rst_s) begin
        if (rst_s) begin
            state <= IDLE;
            q     <= '0;
            rld   <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            rld   <= rld_n;
            tick  <= tick_n;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q;
        rld_n   = rld;
        tick_n  = 1'b0;
        if (load) begin
            // A load on the terminal edge replaces the count, so its tick is dropped.
            q_n     = eff;
            rld_n   = eff;
            state_n = (eff != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (enb) begin
                        if (terminal) begin
                            tick_n = 1'b1;
                            if (periodic) begin
                                q_n = rld;
                            end else begin
                                q_n     = '0;
                                state_n = DONE;
                            end
                        end else begin
                            q_n = q - width'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_zero = (q == '0);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

endmodule
